// File: rtl/conv_tile_ctrl.sv
// 3x3 valid-correlation tile engine: snapshots kernel and tile, then writes one output per cycle
// into a registered result array. Define CONV_TILE_SAT_EN to clamp sums instead of wrapping.
module conv_tile_ctrl #(
  parameter int DATA_W = 32,
  parameter int TILE   = 6
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  start,
  input  logic                                  accumulate,
  input  logic [0:2][0:2][DATA_W-1:0]           kernel_in,
  input  logic [0:TILE-1][0:TILE-1][DATA_W-1:0] tile_in,
  output logic [0:TILE-3][0:TILE-3][DATA_W-1:0] result_out,
  output logic                                  busy,
  output logic                                  done
);
  localparam int OUT = TILE - 2;
  localparam int TW  = $clog2(TILE);
  localparam logic [TW-1:0] LAST = TW'(OUT - 1);
`ifdef CONV_TILE_SAT_EN
  localparam int PW = 2 * DATA_W;
  localparam int FW = 2 * DATA_W + 5;
  localparam logic signed [FW-1:0] SMAX = {{(FW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [FW-1:0] SMIN = {{(FW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  function automatic logic [DATA_W-1:0] sat_fn(input logic signed [FW-1:0] v);
    if (v > SMAX)      return SMAX[DATA_W-1:0];
    else if (v < SMIN) return SMIN[DATA_W-1:0];
    else               return v[DATA_W-1:0];
  endfunction
`else
  localparam int PW = DATA_W;
`endif

  typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, DONE} state_t;
  state_t state, state_nxt;

  logic [0:2][0:2][DATA_W-1:0]           kern_q;
  logic [0:TILE-1][0:TILE-1][DATA_W-1:0] tile_q;
  logic                                  acc_q;
  logic [TW-1:0]                         row_p0, col_p0;
  logic                                  vld_p0, last_p0;
  logic signed [PW-1:0]                  prod_p0 [9];
  logic [DATA_W-1:0]                     old_p0, wr_p0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      acc_q  <= 1'b0;
      row_p0 <= '0;
      col_p0 <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) acc_q <= accumulate;
      if (state == LOAD) begin
        row_p0 <= '0;
        col_p0 <= '0;
      end else if (vld_p0) begin
        if (col_p0 == LAST) begin
          col_p0 <= '0;
          row_p0 <= row_p0 + TW'(1);
        end else begin
          col_p0 <= col_p0 + TW'(1);
        end
      end
    end
  end

  // Operand snapshot: data only, so no reset
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      kern_q <= kernel_in;
      tile_q <= tile_in;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE:    if (start) state_nxt = LOAD;
      LOAD: begin
        busy      = 1'b1;
        state_nxt = COMPUTE;
      end
      COMPUTE: begin
        busy = 1'b1;
        if (last_p0) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign vld_p0  = (state == COMPUTE);
  assign last_p0 = vld_p0 && (row_p0 == LAST) && (col_p0 == LAST);

  // Stage p0: nine parallel products over the current 3x3 window
  for (genvar a = 0; a < 3; a++) begin : g_krow
    for (genvar b = 0; b < 3; b++) begin : g_kcol
      logic [TW-1:0] ti, tj;
      assign ti = row_p0 + TW'(a);
      assign tj = col_p0 + TW'(b);
      assign prod_p0[a*3+b] = PW'($signed(kern_q[a][b])) * PW'($signed(tile_q[ti][tj]));
    end
  end

  always_comb begin
    old_p0 = '0;
    for (int r = 0; r < OUT; r++)
      for (int c = 0; c < OUT; c++)
        if (row_p0 == TW'(r) && col_p0 == TW'(c)) old_p0 = result_out[r][c];
  end

`ifdef CONV_TILE_SAT_EN
  logic signed [FW-1:0] sum_p0;
  always_comb begin
    sum_p0 = '0;
    for (int k = 0; k < 9; k++) sum_p0 = sum_p0 + FW'(prod_p0[k]);
    if (acc_q) sum_p0 = sum_p0 + FW'($signed(old_p0));
    wr_p0 = sat_fn(sum_p0);
  end
`else
  logic signed [DATA_W-1:0] sum_p0;
  always_comb begin
    sum_p0 = '0;
    for (int k = 0; k < 9; k++) sum_p0 = sum_p0 + prod_p0[k];
    wr_p0 = acc_q ? DATA_W'(sum_p0 + $signed(old_p0)) : DATA_W'(sum_p0);
  end
`endif

  // Stage p1: result array write-back
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result_out <= '0;
    end else if (vld_p0) begin
      for (int r = 0; r < OUT; r++)
        for (int c = 0; c < OUT; c++)
          if (row_p0 == TW'(r) && col_p0 == TW'(c)) result_out[r][c] <= wr_p0;
    end
  end

endmodule

// File: tb/tb_conv_tile_ctrl.sv
// Scoreboard bench for conv_tile_ctrl: driver queues expected results per start, monitor checks on done.
`timescale 1ns/1ps
module tb_conv_tile_ctrl;
  localparam int DW  = 32;
  localparam int TL  = 6;
  localparam int OUT = TL - 2;
  localparam int LAT = OUT * OUT + 2;

  typedef logic [0:2][0:2][DW-1:0]     kern_t;
  typedef logic [0:TL-1][0:TL-1][DW-1:0] tile_t;
  typedef logic [0:OUT-1][0:OUT-1][DW-1:0] res_t;
  typedef struct { res_t res; int done_edge; } exp_t;

  logic  clk = 1'b0;
  logic  rst_n, start, accumulate;
  kern_t kernel_in;
  tile_t tile_in;
  res_t  result_out;
  logic  busy, done;

  conv_tile_ctrl #(.DATA_W(DW), .TILE(TL)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .accumulate(accumulate),
    .kernel_in(kernel_in), .tile_in(tile_in), .result_out(result_out),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t exp_q[$];
  res_t model_res;
  int   n_chk = 0, n_fail = 0, done_count = 0, dc;
  logic prev_done = 1'b0;
  kern_t kv, kv2;
  tile_t tv;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endfunction

  // Reference: full-precision correlation, then wrap or clamp
  function automatic res_t model(input kern_t k, input tile_t t, input logic acc, input res_t old);
    res_t o;
    logic signed [127:0] s, kk, tt, ov;
    for (int r = 0; r < OUT; r++)
      for (int c = 0; c < OUT; c++) begin
        s = '0;
        for (int a = 0; a < 3; a++)
          for (int b = 0; b < 3; b++) begin
            kk = $signed(k[a][b]);
            tt = $signed(t[r+a][c+b]);
            s  = s + kk * tt;
          end
        if (acc) begin
          ov = $signed(old[r][c]);
          s  = s + ov;
        end
`ifdef CONV_TILE_SAT_EN
        if (s > 128'sd2147483647)       o[r][c] = 32'h7FFF_FFFF;
        else if (s < -128'sd2147483648) o[r][c] = 32'h8000_0000;
        else                            o[r][c] = s[DW-1:0];
`else
        o[r][c] = s[DW-1:0];
`endif
      end
    return o;
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    if (done) begin
      check("done_single_cycle", {63'd0, prev_done}, 64'd0);
      check("busy_in_done", {63'd0, busy}, 64'd0);
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL done_unexpected: done seen at edge %0d, expected no pending operation", cyc + 1);
      end else begin
        e = exp_q.pop_front();
        check("done_latency_edge", 64'(cyc + 1), 64'(e.done_edge));
        for (int r = 0; r < OUT; r++)
          for (int c = 0; c < OUT; c++)
            check($sformatf("result[%0d][%0d]", r, c), 64'(result_out[r][c]), 64'(e.res[r][c]));
      end
      done_count++;
    end
    prev_done = done;
  end

  task automatic issue(input kern_t k, input tile_t t, input logic acc);
    exp_t e;
    @(negedge clk);
    kernel_in  = k;
    tile_in    = t;
    accumulate = acc;
    start      = 1'b1;
    e.res      = model(k, t, acc, model_res);
    model_res  = e.res;
    @(posedge clk);
    #1;
    e.done_edge = cyc + LAT;
    exp_q.push_back(e);
    start      = 1'b0;
    accumulate = ~acc;
    kernel_in  = '1;
    tile_in    = ~t;
  endtask

  task automatic wait_done(input string tag);
    int c0 = done_count;
    int n  = 0;
    while (done_count == c0 && n < 60) begin
      @(negedge clk);
      #1;
      n++;
    end
    n_chk++;
    if (done_count == c0) begin
      n_fail++;
      $display("FAIL %s_timeout: no done within %0d cycles, expected a done pulse", tag, n);
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (n) @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    model_res = '0;
  endtask

  task automatic check_idle_clear(input string tag);
    check({tag, "_busy"}, {63'd0, busy}, 64'd0);
    check({tag, "_done"}, {63'd0, done}, 64'd0);
    check({tag, "_results_zero"}, {63'd0, |result_out}, 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; accumulate = 1'b0;
    kernel_in = '0; tile_in = '0; model_res = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check_idle_clear("reset");

    // Identity kernel
    kv = '0; kv[1][1] = 32'd1;
    for (int i = 0; i < TL; i++) for (int j = 0; j < TL; j++) tv[i][j] = 32'(i * 6 + j + 1);
    issue(kv, tv, 1'b0);
    check("busy_after_start", {63'd0, busy}, 64'd1);
    wait_done("ident");
    check("ident_r00", 64'(result_out[0][0]), 64'd8);
    check("ident_r03", 64'(result_out[0][3]), 64'd11);
    check("ident_r33", 64'(result_out[3][3]), 64'd29);

    // All ones, overwrite then accumulate
    for (int a = 0; a < 3; a++) for (int b = 0; b < 3; b++) kv[a][b] = 32'd1;
    for (int i = 0; i < TL; i++) for (int j = 0; j < TL; j++) tv[i][j] = 32'd1;
    issue(kv, tv, 1'b0);
    wait_done("ones");
    check("ones_r21", 64'(result_out[2][1]), 64'd9);
    issue(kv, tv, 1'b1);
    wait_done("ones_acc");
    check("ones_acc_r30", 64'(result_out[3][0]), 64'd18);

    // Kernel 1..9 with a start pulse mid-COMPUTE that must be ignored
    for (int a = 0; a < 3; a++) for (int b = 0; b < 3; b++) kv[a][b] = 32'(a * 3 + b + 1);
    for (int i = 0; i < TL; i++) for (int j = 0; j < TL; j++) tv[i][j] = 32'((i + j) % 10 + 1);
    issue(kv, tv, 1'b0);
    repeat (8) @(negedge clk);
    kernel_in = '0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_mid_compute", {63'd0, busy}, 64'd1);
    wait_done("k19");
    check("k19_r00", 64'(result_out[0][0]), 64'd159);
    dc = done_count;
    repeat (30) @(negedge clk);
    check("no_extra_done", 64'(done_count), 64'(dc));

    // Overflow boundary: positive and negative
    kv = '0; kv[1][1] = 32'd2;
    for (int i = 0; i < TL; i++) for (int j = 0; j < TL; j++) tv[i][j] = 32'h4000_0000;
    issue(kv, tv, 1'b0);
    wait_done("ovf_pos");
`ifdef CONV_TILE_SAT_EN
    check("ovf_pos_r12", 64'(result_out[1][2]), 64'h7FFF_FFFF);
`else
    check("ovf_pos_r12", 64'(result_out[1][2]), 64'h8000_0000);
`endif
    kv[1][1] = 32'd3;
    for (int i = 0; i < TL; i++) for (int j = 0; j < TL; j++) tv[i][j] = 32'hC000_0000;
    issue(kv, tv, 1'b0);
    wait_done("ovf_neg");
`ifdef CONV_TILE_SAT_EN
    check("ovf_neg_r21", 64'(result_out[2][1]), 64'h8000_0000);
`else
    check("ovf_neg_r21", 64'(result_out[2][1]), 64'h4000_0000);
`endif

    // Mixed signs accumulated on top of previous results
    for (int a = 0; a < 3; a++) for (int b = 0; b < 3; b++) kv[a][b] = 32'(a * 3 + b - 4);
    for (int i = 0; i < TL; i++) for (int j = 0; j < TL; j++) tv[i][j] = 32'(i * 7 - j * 5);
    issue(kv, tv, 1'b1);
    wait_done("signed_acc");

    // Reset during COMPUTE aborts with no done
    kv = '0; kv[1][1] = 32'd1;
    for (int i = 0; i < TL; i++) for (int j = 0; j < TL; j++) tv[i][j] = 32'(i * 6 + j + 1);
    issue(kv, tv, 1'b0);
    repeat (6) @(negedge clk);
    dc = done_count;
    do_reset(1);
    check_idle_clear("abort");
    repeat (25) @(negedge clk);
    check("abort_no_done", 64'(done_count), 64'(dc));
    issue(kv, tv, 1'b0);
    wait_done("after_abort");
    check("after_abort_r00", 64'(result_out[0][0]), 64'd8);

    // Start during DONE ignored; start in the cycle after done accepted
    for (int a = 0; a < 3; a++) for (int b = 0; b < 3; b++) kv[a][b] = 32'(b - a);
    for (int a = 0; a < 3; a++) for (int b = 0; b < 3; b++) kv2[a][b] = 32'(a + 2 * b + 1);
    for (int i = 0; i < TL; i++) for (int j = 0; j < TL; j++) tv[i][j] = 32'(i * i + 3 * j);
    issue(kv, tv, 1'b0);
    wait_done("b2b_first");
    kernel_in = kv2;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    check("start_in_done_ignored", {63'd0, busy}, 64'd0);
    issue(kv, tv, 1'b0);
    wait_done("b2b_a");
    issue(kv2, tv, 1'b0);
    wait_done("b2b_b");

    repeat (5) @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
